// File: rtl/btn_matrix_scanner.sv
// ============================================================================
// Module   : btn_matrix_scanner
// Purpose  : Column-driven keypad matrix scanner with per-key debounce and a
//            show-ahead press/release event FIFO (valid/ready handshake).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_matrix_scanner #(
    parameter int ROWS       = 5,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 16,
    parameter int SETTLE     = 4,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int CODE_W    = $clog2(ROWS*COLS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [COLS-1:0]        col_drive,
    input  logic [ROWS-1:0]        row_sense,
    output logic [ROWS*COLS-1:0]   key_state,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic                   evt_press,
    output logic [CODE_W-1:0]      evt_code,
    output logic                   evt_overflow,
    input  logic                   ovf_clear
);

    localparam int c_nkeys  = ROWS * COLS;
    localparam int c_dw     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_colw   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_cntw   = $clog2(DEBOUNCE + 1);
    localparam int c_ptrw   = $clog2(FIFO_DEPTH);
    localparam int c_fillw  = c_ptrw + 1;
    localparam int c_ew     = CODE_W + 1;

    localparam logic [c_dw-1:0]    c_dwell_last = c_dw'(SCAN_DIV - 1);
    localparam logic [c_dw-1:0]    c_settle     = c_dw'(SETTLE);
    localparam logic [c_dw-1:0]    c_eval_first = c_dw'(SETTLE + 1);
    localparam logic [c_dw-1:0]    c_eval_last  = c_dw'(SETTLE + ROWS);
    localparam logic [c_colw-1:0]  c_col_last   = c_colw'(COLS - 1);
    localparam logic [c_cntw-1:0]  c_cnt_last   = c_cntw'(DEBOUNCE - 1);
    localparam logic [c_fillw-1:0] c_depth      = c_fillw'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Scan / debounce state
    // ------------------------------------------------------------------
    logic [c_colw-1:0]  r_col;
    logic [c_dw-1:0]    r_dwell;
    logic [ROWS-1:0]    r_latch;
    logic [c_nkeys-1:0] r_key_state;
    logic [c_cntw-1:0]  r_cnt [c_nkeys];

    logic               w_eval_en;
    logic [c_dw-1:0]    w_row;
    logic [ROWS-1:0]    w_row_bit;
    logic               w_raw;
    logic [CODE_W-1:0]  w_code;
    logic               w_state;
    logic [c_cntw-1:0]  w_cnt;
    logic               w_cnt_done;
    logic               w_push;

    assign col_drive  = ~(COLS'(1) << r_col);
    assign key_state  = r_key_state;

    // One key per cycle: row index follows the dwell counter after the sample
    assign w_eval_en  = (r_dwell >= c_eval_first) && (r_dwell <= c_eval_last);
    assign w_row      = r_dwell - c_eval_first;
    assign w_row_bit  = r_latch & (ROWS'(1) << w_row);
    assign w_raw      = ~|w_row_bit;
    assign w_code     = CODE_W'(w_row) * CODE_W'(COLS) + CODE_W'(r_col);
    assign w_state    = r_key_state[w_code];
    assign w_cnt      = r_cnt[w_code];
    assign w_cnt_done = (w_cnt == c_cnt_last);
    assign w_push     = w_eval_en && (w_raw != w_state) && w_cnt_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_dwell     <= '0;
            r_latch     <= '1;
            r_key_state <= '0;
            for (int k = 0; k < c_nkeys; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            if (r_dwell == c_dwell_last) begin
                r_dwell <= '0;
                r_col   <= (r_col == c_col_last) ? '0 : r_col + c_colw'(1);
            end else begin
                r_dwell <= r_dwell + c_dw'(1);
            end

            if (r_dwell == c_settle) begin
                r_latch <= row_sense;
            end

            if (w_eval_en) begin
                if (w_raw == w_state) begin
                    r_cnt[w_code] <= '0;
                end else if (w_cnt_done) begin
                    r_key_state[w_code] <= w_raw;
                    r_cnt[w_code]       <= '0;
                end else begin
                    r_cnt[w_code] <= w_cnt + c_cntw'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (show-ahead, no empty bypass)
    // ------------------------------------------------------------------
    logic [c_ew-1:0]    r_mem [FIFO_DEPTH];
    logic [c_ptrw-1:0]  r_wr_ptr;
    logic [c_ptrw-1:0]  r_rd_ptr;
    logic [c_fillw-1:0] r_fill;
    logic               r_ovf;

    logic               w_valid;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;
    logic [c_ew-1:0]    w_head;

    assign w_valid = (r_fill != '0);
    assign w_full  = (r_fill == c_depth);
    assign w_pop   = w_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    assign evt_valid    = w_valid;
    assign evt_press    = w_valid & w_head[CODE_W];
    assign evt_code     = w_valid ? w_head[CODE_W-1:0] : '0;
    assign evt_overflow = r_ovf;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_raw, w_code};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptrw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptrw'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_fill <= r_fill + c_fillw'(1);
                2'b01:   r_fill <= r_fill - c_fillw'(1);
                default: r_fill <= r_fill;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clear) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_matrix_scanner.sv
// ============================================================================
// Module   : tb_btn_matrix_scanner
// Purpose  : Self-checking bench for btn_matrix_scanner with a keypad model
//            and an event scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_matrix_scanner;

    localparam int ROWS = 5;
    localparam int COLS = 4;
    localparam int NK   = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    col_drive;
    logic [4:0]    row_sense;
    logic [19:0]   key_state;
    logic          evt_valid;
    logic          evt_ready;
    logic          evt_press;
    logic [4:0]    evt_code;
    logic          evt_overflow;
    logic          ovf_clear;

    logic [NK-1:0] keys;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            last_pop = -100;
    int            prev_pop = -200;

    typedef struct packed {
        logic       press;
        logic [4:0] code;
    } evt_t;

    typedef struct {
        int         n;
        logic [3:0] col;
    } col_vec_t;

    typedef struct {
        int   code;
        logic press;
    } key_vec_t;

    evt_t     exp_q[$];
    evt_t     mon_e;
    col_vec_t cv[9];
    key_vec_t kv[8];

    btn_matrix_scanner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .col_drive    (col_drive),
        .row_sense    (row_sense),
        .key_state    (key_state),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_press    (evt_press),
        .evt_code     (evt_code),
        .evt_overflow (evt_overflow),
        .ovf_clear    (ovf_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad: a closed key pulls its row low while its column is driven
    always_comb begin
        row_sense = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (keys[r*COLS+c] && !col_drive[c]) begin
                    row_sense[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input logic p, input int code);
        evt_t e;
        e.press = p;
        e.code  = 5'(code);
        exp_q.push_back(e);
    endtask

    // Every accepted event must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: press=%0d code=%0d with no event expected", evt_press, evt_code);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_code", 32'(evt_code), 32'(mon_e.code));
                chk("sb_press", 32'(evt_press), 32'(mon_e.press));
            end
            prev_pop = last_pop;
            last_pop = cyc;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_col_drive"}, 32'(col_drive), 32'hE);
        chk({tag, "_key_state"}, 32'(key_state), 32'h0);
        chk({tag, "_evt_valid"}, 32'(evt_valid), 32'h0);
        chk({tag, "_evt_press"}, 32'(evt_press), 32'h0);
        chk({tag, "_evt_code"}, 32'(evt_code), 32'h0);
        chk({tag, "_evt_overflow"}, 32'(evt_overflow), 32'h0);
    endtask

    // Leaves the bench at the first negedge of a column's dwell (d=0)
    task automatic sync_col(input logic [3:0] pat);
        int g = 0;
        while (col_drive == pat && g < 200) begin
            @(negedge clk);
            g++;
        end
        while (col_drive != pat && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) begin
            total++;
            bad++;
            $display("FAIL sync_col: col_drive=%b never reached %b", col_drive, pat);
        end
    endtask

    // Key r2/c1: third closed evaluation is at offset 2*64+7 from column start
    task automatic check_latency(input string tag);
        sync_col(4'b1101);
        keys[9] = 1'b1;
        expect_evt(1'b1, 9);
        step(2*64 + 7);
        chk({tag, "_early_state"}, 32'(key_state[9]), 32'h0);
        chk({tag, "_early_valid"}, 32'(evt_valid), 32'h0);
        step(1);
        chk({tag, "_state"}, 32'(key_state[9]), 32'h1);
        chk({tag, "_valid"}, 32'(evt_valid), 32'h1);
        chk({tag, "_code"}, 32'(evt_code), 32'd9);
        chk({tag, "_press"}, 32'(evt_press), 32'h1);
        keys[9] = 1'b0;
        expect_evt(1'b0, 9);
        step(4*64);
        chk({tag, "_rel_state"}, 32'(key_state[9]), 32'h0);
        chk({tag, "_rel_drain"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int          cur;
        int          ov_codes[9];
        logic [19:0] ov_mask;

        keys      = '0;
        evt_ready = 1'b1;
        ovf_clear = 1'b0;

        cv[0] = '{0,  4'b1110}; cv[1] = '{15, 4'b1110}; cv[2] = '{16, 4'b1101};
        cv[3] = '{31, 4'b1101}; cv[4] = '{32, 4'b1011}; cv[5] = '{47, 4'b1011};
        cv[6] = '{48, 4'b0111}; cv[7] = '{63, 4'b0111}; cv[8] = '{64, 4'b1110};

        kv[0] = '{0, 1'b1};  kv[1] = '{0, 1'b0};  kv[2] = '{19, 1'b1}; kv[3] = '{6, 1'b1};
        kv[4] = '{19, 1'b0}; kv[5] = '{6, 1'b0};  kv[6] = '{13, 1'b1}; kv[7] = '{13, 1'b0};

        ov_codes = '{0, 4, 8, 12, 16, 1, 5, 9, 13};

        // Reset values, then the column walk
        step(3);
        chk_reset("rst");
        rst_n = 1'b1;
        cur = 0;
        for (int i = 0; i < 9; i++) begin
            step(cv[i].n - cur);
            cur = cv[i].n;
            chk($sformatf("col_drive_n%0d", cv[i].n), 32'(col_drive), 32'(cv[i].col));
        end

        check_latency("lat");

        // Bounce: 2 closed, 1 open, 2 closed, 1 open -> never reaches 3
        sync_col(4'b1101);
        keys[9] = 1'b1;
        step(128);
        keys[9] = 1'b0;
        step(64);
        keys[9] = 1'b1;
        step(128);
        keys[9] = 1'b0;
        step(128);
        chk("bounce_state", 32'(key_state), 32'h0);
        chk("bounce_drain", 32'(exp_q.size()), 32'h0);

        // Two keys in column 3, rows 0 and 4
        sync_col(4'b0111);
        keys[3]  = 1'b1;
        keys[19] = 1'b1;
        expect_evt(1'b1, 3);
        expect_evt(1'b1, 19);
        step(4*64);
        chk("col3_state", 32'(key_state), 32'h80008);
        chk("col3_drain", 32'(exp_q.size()), 32'h0);
        chk("col3_pop_gap", 32'(last_pop - prev_pop), 32'd4);
        keys[3]  = 1'b0;
        keys[19] = 1'b0;
        expect_evt(1'b0, 3);
        expect_evt(1'b0, 19);
        step(4*64);
        chk("col3_rel_state", 32'(key_state), 32'h0);
        chk("col3_rel_drain", 32'(exp_q.size()), 32'h0);

        // Single-key vectors
        for (int i = 0; i < 8; i++) begin
            keys[kv[i].code] = kv[i].press;
            expect_evt(kv[i].press, kv[i].code);
            step(4*64);
            chk($sformatf("vec%0d_state", i), 32'(key_state[kv[i].code]), 32'(kv[i].press));
            chk($sformatf("vec%0d_drain", i), 32'(exp_q.size()), 32'h0);
        end

        // Overflow: 9 presses into an 8-deep stalled FIFO
        evt_ready = 1'b0;
        ov_mask   = '0;
        sync_col(4'b1110);
        for (int i = 0; i < 9; i++) begin
            keys[ov_codes[i]] = 1'b1;
            ov_mask[ov_codes[i]] = 1'b1;
            if (i < 8) expect_evt(1'b1, ov_codes[i]);
        end
        step(200);
        chk("ovf_flag", 32'(evt_overflow), 32'h1);
        chk("ovf_valid", 32'(evt_valid), 32'h1);
        chk("ovf_head_code", 32'(evt_code), 32'h0);
        chk("ovf_head_press", 32'(evt_press), 32'h1);
        chk("ovf_key_state", 32'(key_state), 32'(ov_mask));
        step(5);
        chk("ovf_hold_code", 32'(evt_code), 32'h0);
        chk("ovf_hold_valid", 32'(evt_valid), 32'h1);
        evt_ready = 1'b1;
        step(20);
        chk("ovf_drain", 32'(exp_q.size()), 32'h0);
        chk("ovf_empty_valid", 32'(evt_valid), 32'h0);
        chk("ovf_empty_code", 32'(evt_code), 32'h0);
        chk("ovf_empty_press", 32'(evt_press), 32'h0);
        chk("ovf_sticky", 32'(evt_overflow), 32'h1);
        ovf_clear = 1'b1;
        step(1);
        ovf_clear = 1'b0;
        chk("ovf_cleared", 32'(evt_overflow), 32'h0);
        sync_col(4'b1110);
        for (int i = 0; i < 9; i++) begin
            keys[ov_codes[i]] = 1'b0;
            expect_evt(1'b0, ov_codes[i]);
        end
        step(4*64);
        chk("ovf_rel_drain", 32'(exp_q.size()), 32'h0);
        chk("ovf_rel_state", 32'(key_state), 32'h0);

        // Asynchronous reset with two queued events and key 9 at count 2
        evt_ready = 1'b0;
        sync_col(4'b1110);
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        step(64);
        keys[9] = 1'b1;
        step(101);
        chk("prerst_valid", 32'(evt_valid), 32'h1);
        chk("prerst_code", 32'(evt_code), 32'h0);
        chk("prerst_state", 32'(key_state), 32'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        exp_q.delete();
        keys[0]   = 1'b0;
        keys[4]   = 1'b0;
        evt_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check_latency("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
